// File: rtl/spi_reg_sequencer_pkg.sv
// Shared types and constants for the SPI register sequencer.
package spi_reg_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CMD_RD_BIT = 7;

  localparam logic [BYTE_W-1:0] ID_BYTE_DEFAULT = 8'h36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_e;

endpackage

// File: rtl/spi_reg_sequencer_if.sv
// Single-port register file access bus: requester drives strobe/fields, file returns read data.
interface spi_reg_sequencer_if #(
  parameter int unsigned ADDR_W = 7
);
  logic              reg_en;
  logic              reg_we;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_en,
    output reg_we,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_en,
    input  reg_we,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/spi_reg_sequencer_arb.sv
// Fixed-priority 2:1 register-port mux: a pending SPI access always wins over the local requester.
module reg_port_arbiter #(
  parameter int unsigned ADDR_W = 7
) (
  input  logic              spi_pending,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [7:0]        spi_wdata,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [7:0]        loc_wdata,
  output logic              reg_en_c,
  output logic              reg_we_c,
  output logic [ADDR_W-1:0] reg_addr_c,
  output logic [7:0]        reg_wdata_c,
  output logic              loc_gnt_c
);

  // Select the access source; local side is granted only in cycles SPI leaves idle.
  always_comb begin
    loc_gnt_c   = loc_req & ~spi_pending;
    reg_en_c    = spi_pending | loc_req;
    reg_we_c    = spi_we;
    reg_addr_c  = spi_addr;
    reg_wdata_c = spi_wdata;
    if (!spi_pending) begin
      reg_we_c    = loc_req & loc_we;
      reg_addr_c  = loc_addr;
      reg_wdata_c = loc_wdata;
    end
  end

endmodule

// File: rtl/spi_reg_sequencer.sv
// SPI frame command decoder and burst sequencer in front of a shared register port.
module spi_reg_sequencer
  import spi_reg_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 7,
  parameter logic [BYTE_W-1:0] ID_BYTE = ID_BYTE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ssel_active,
  input  logic                rx_valid,
  input  logic [BYTE_W-1:0]   rx_data,
  output logic [BYTE_W-1:0]   tx_data,
  spi_reg_sequencer_if.master reg_bus,
  input  logic                loc_req,
  input  logic                loc_we,
  input  logic [ADDR_W-1:0]   loc_addr,
  input  logic [BYTE_W-1:0]   loc_wdata,
  output logic                loc_gnt,
  output logic [BYTE_W-1:0]   loc_rdata,
  output logic                busy,
  output logic                err
);

  state_e              state_q, state_d;
  logic                ssel_q, ssel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                err_q, err_d;
  logic                spi_pending_q, spi_pending_d;
  logic                spi_we_q, spi_we_d;
  logic [ADDR_W-1:0]   spi_addr_q, spi_addr_d;
  logic [BYTE_W-1:0]   spi_wdata_q, spi_wdata_d;
  logic                rd_return_q, rd_return_d;
  logic [ADDR_W-1:0]   cmd_addr;

  assign cmd_addr = rx_data[ADDR_W-1:0];

  // State and datapath registers; reset cancels any access not yet on the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ssel_q        <= 1'b0;
      addr_q        <= '0;
      tx_data_q     <= ID_BYTE;
      err_q         <= 1'b0;
      spi_pending_q <= 1'b0;
      spi_we_q      <= 1'b0;
      spi_addr_q    <= '0;
      spi_wdata_q   <= '0;
      rd_return_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ssel_q        <= ssel_d;
      addr_q        <= addr_d;
      tx_data_q     <= tx_data_d;
      err_q         <= err_d;
      spi_pending_q <= spi_pending_d;
      spi_we_q      <= spi_we_d;
      spi_addr_q    <= spi_addr_d;
      spi_wdata_q   <= spi_wdata_d;
      rd_return_q   <= rd_return_d;
    end
  end

  // Frame FSM: decode command, then issue one write or prefetch read per received byte.
  always_comb begin
    state_d       = state_q;
    ssel_d        = ssel_active;
    addr_d        = addr_q;
    tx_data_d     = tx_data_q;
    err_d         = err_q;
    spi_pending_d = 1'b0;
    spi_we_d      = spi_we_q;
    spi_addr_d    = spi_addr_q;
    spi_wdata_d   = spi_wdata_q;
    rd_return_d   = spi_pending_q & ~spi_we_q;

    // Returning SPI read data becomes the next byte to shift out.
    if (rd_return_q) begin
      tx_data_d = reg_bus.reg_rdata;
    end

    if (!ssel_active) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ssel_q) begin
            state_d   = CMD;
            tx_data_d = ID_BYTE;
            err_d     = 1'b0;
          end
        end
        default: begin
          if (rx_valid) begin
            if (spi_pending_q) begin
              // Byte arrived before the previous access left the port: drop it.
              err_d = 1'b1;
            end else if (state_q == CMD) begin
              if (rx_data[CMD_RD_BIT]) begin
                state_d       = RDATA;
                spi_pending_d = 1'b1;
                spi_we_d      = 1'b0;
                spi_addr_d    = cmd_addr;
                addr_d        = cmd_addr + ADDR_W'(1);
              end else begin
                state_d = WDATA;
                addr_d  = cmd_addr;
              end
            end else begin
              spi_pending_d = 1'b1;
              spi_we_d      = (state_q == WDATA);
              spi_addr_d    = addr_q;
              spi_wdata_d   = rx_data;
              addr_d        = addr_q + ADDR_W'(1);
            end
          end
        end
      endcase
    end
  end

  logic              arb_en_c;
  logic              arb_we_c;
  logic [ADDR_W-1:0] arb_addr_c;
  logic [7:0]        arb_wdata_c;

  reg_port_arbiter #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .spi_pending (spi_pending_q),
    .spi_we      (spi_we_q),
    .spi_addr    (spi_addr_q),
    .spi_wdata   (spi_wdata_q),
    .loc_req     (loc_req),
    .loc_we      (loc_we),
    .loc_addr    (loc_addr),
    .loc_wdata   (loc_wdata),
    .reg_en_c    (arb_en_c),
    .reg_we_c    (arb_we_c),
    .reg_addr_c  (arb_addr_c),
    .reg_wdata_c (arb_wdata_c),
    .loc_gnt_c   (loc_gnt)
  );

  assign reg_bus.reg_en    = arb_en_c;
  assign reg_bus.reg_we    = arb_we_c;
  assign reg_bus.reg_addr  = arb_addr_c;
  assign reg_bus.reg_wdata = arb_wdata_c;

  assign loc_rdata = reg_bus.reg_rdata;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule
